// File: rtl/bus_irq_if.sv
// Processor-side address/strobe and interrupt handshake signals of the
// interrupt concentrator, plus the per-source raise/ack pairs.
// BUS_DATA is a shared tristate net, so it stays a plain inout port on the
// controller instead of living in this bundle.
interface bus_irq_if #(
    parameter int N_SRC = 8
);
    logic [7:0]       BUS_ADDR;
    logic             BUS_WE;
    logic [N_SRC-1:0] SRC_RAISE;
    logic [N_SRC-1:0] SRC_ACK;
    logic             INT_RAISE;
    logic             INT_ACK;

    // Processor and peripherals drive requests/addresses, observe acks.
    modport master (
        output BUS_ADDR, BUS_WE, SRC_RAISE, INT_ACK,
        input  SRC_ACK, INT_RAISE
    );

    // Interrupt controller side.
    modport slave (
        input  BUS_ADDR, BUS_WE, SRC_RAISE, INT_ACK,
        output SRC_ACK, INT_RAISE
    );
endinterface

// File: rtl/bus_irq_ctrl.sv
// Interrupt concentrator: latches up to 8 peripheral requests into PENDING,
// masks them, picks one by fixed or round-robin priority and presents it to
// the processor on a single registered interrupt line. Four bus registers:
// PENDING (W1C), MASK, VECTOR (read-only) and CTRL.
module bus_irq_ctrl #(
    parameter logic [7:0] BASE_ADDR  = 8'hD0,
    parameter int         N_SRC      = 8,
    parameter logic [7:0] MASK_RESET = 8'h00
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    bus_irq_if.slave   bus
);
    localparam logic [7:0] SRC_BITS   = 8'((9'd1 << N_SRC) - 9'd1);
    localparam logic [2:0] LAST_RESET = 3'(N_SRC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAISED = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           stateR;
    state_t           stateNextS;
    logic [7:0]       pendingR;
    logic [7:0]       maskR;
    logic [1:0]       ctrlR;
    logic             vecValidR;
    logic [2:0]       vecIdxR;
    logic [2:0]       lastR;
    logic [2:0]       curR;
    logic             intRaiseR;
    logic [N_SRC-1:0] srcAckR;
    logic [7:0]       rdDataR;
    logic             rdDriveR;

    logic [7:0]       offsetS;
    logic             inRangeS;
    logic             wrS;
    logic             rdS;
    logic [1:0]       regSelS;
    logic [7:0]       raiseS;
    logic [7:0]       captureS;
    logic [7:0]       w1cS;
    logic [7:0]       ackClrS;
    logic [7:0]       eligibleS;
    logic [7:0]       rdMuxS;
    logic [2:0]       selS;
    logic [2:0]       rrIdxS;
    logic             foundS;
    logic             latchCurS;
    logic             ackTakeS;

    assign offsetS   = bus.BUS_ADDR - BASE_ADDR;
    assign inRangeS  = (offsetS < 8'd4);
    assign regSelS   = offsetS[1:0];
    assign wrS       = inRangeS & bus.BUS_WE;
    assign rdS       = inRangeS & ~bus.BUS_WE;
    assign raiseS    = 8'(bus.SRC_RAISE);
    // Only a request whose pending bit is clear is captured (and acked).
    assign captureS  = raiseS & ~pendingR & SRC_BITS;
    assign w1cS      = (wrS && (regSelS == 2'd0)) ? BUS_DATA : 8'h00;
    assign ackClrS   = ackTakeS ? (8'd1 << curR) : 8'h00;
    assign eligibleS = ctrlR[0] ? (pendingR & maskR) : 8'h00;

    assign BUS_DATA      = rdDriveR ? rdDataR : 8'hzz;
    assign bus.INT_RAISE = intRaiseR;
    assign bus.SRC_ACK   = srcAckR;

    // Priority pick: lowest index, or first set bit after the last serviced one.
    always_comb begin
        selS   = 3'd0;
        rrIdxS = 3'd0;
        foundS = 1'b0;
        if (ctrlR[1]) begin
            for (int k = 1; k <= N_SRC; k++) begin
                rrIdxS = 3'((int'(lastR) + k) % N_SRC);
                selS   = (!foundS && eligibleS[rrIdxS]) ? rrIdxS : selS;
                foundS = foundS | eligibleS[rrIdxS];
            end
        end else begin
            for (int k = N_SRC - 1; k >= 0; k--) begin
                selS = eligibleS[k] ? 3'(k) : selS;
            end
        end
    end

    // Next-state logic: commit a source in IDLE, wait for ack, force a low gap.
    always_comb begin
        stateNextS = stateR;
        latchCurS  = 1'b0;
        ackTakeS   = 1'b0;
        case (stateR)
            IDLE: begin
                if (eligibleS != 8'h00) begin
                    stateNextS = RAISED;
                    latchCurS  = 1'b1;
                end else begin
                    stateNextS = IDLE;
                end
            end
            RAISED: begin
                if (bus.INT_ACK) begin
                    stateNextS = HOLD;
                    ackTakeS   = 1'b1;
                end else begin
                    stateNextS = RAISED;
                end
            end
            HOLD:    stateNextS = IDLE;
            default: stateNextS = IDLE;
        endcase
    end

    // Register read multiplexer; unused bits read as zero.
    always_comb begin
        rdMuxS = 8'h00;
        case (regSelS)
            2'd0:    rdMuxS = pendingR;
            2'd1:    rdMuxS = maskR;
            2'd2:    rdMuxS = {vecValidR, 4'b0000, vecIdxR};
            2'd3:    rdMuxS = {6'b000000, ctrlR};
            default: rdMuxS = 8'h00;
        endcase
    end

    // FSM state register and registered interrupt line.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            stateR    <= IDLE;
            intRaiseR <= 1'b0;
        end else begin
            stateR    <= stateNextS;
            intRaiseR <= (stateNextS == RAISED);
        end
    end

    // Pending bits: capture beats both W1C and the ack clear of the same bit.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pendingR <= 8'h00;
            srcAckR  <= '0;
        end else begin
            pendingR <= ((pendingR & ~w1cS & ~ackClrS) | captureS) & SRC_BITS;
            srcAckR  <= captureS[N_SRC-1:0];
        end
    end

    // MASK and CTRL bus writes.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            maskR <= MASK_RESET & SRC_BITS;
            ctrlR <= 2'b00;
        end else begin
            if (wrS && (regSelS == 2'd1)) maskR <= BUS_DATA & SRC_BITS;
            if (wrS && (regSelS == 2'd3)) ctrlR <= BUS_DATA[1:0];
        end
    end

    // Committed source, vector and round-robin history.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            curR      <= 3'd0;
            vecValidR <= 1'b0;
            vecIdxR   <= 3'd0;
            lastR     <= LAST_RESET;
        end else begin
            if (latchCurS) curR <= selS;
            if (ackTakeS) begin
                vecValidR <= 1'b1;
                vecIdxR   <= curR;
                lastR     <= curR;
            end
        end
    end

    // Read data is registered and driven onto the bus one cycle later.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rdDataR  <= 8'h00;
            rdDriveR <= 1'b0;
        end else begin
            rdDataR  <= rdS ? rdMuxS : rdDataR;
            rdDriveR <= rdS;
        end
    end
endmodule

// File: tb/tb_bus_irq_ctrl.sv
// Directed bench for bus_irq_ctrl. Register reads push their expected value
// into a scoreboard queue; a monitor pops and compares when the read data is
// on the bus. The data net is pulled up so an undriven bus reads 8'hFF.
module tb_bus_irq_ctrl;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    tri1 [7:0] busData;
    logic [7:0] tbData = 8'h00;
    logic tbDrive = 1'b0;
    logic rdReq = 1'b0;
    logic rdPend = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [7:0] expQ[$];
    string nmQ[$];
    logic [7:0] expVec[7];

    bus_irq_if #(.N_SRC(8)) bif();

    bus_irq_ctrl #(.BASE_ADDR(8'hD0), .N_SRC(8), .MASK_RESET(8'h00)) dut (
        .CLK(clk), .RESET(rstN), .BUS_DATA(busData), .bus(bif)
    );

    assign busData = tbDrive ? tbData : 8'hzz;

    always #5 clk = ~clk;

    always @(posedge clk) rdPend <= rdReq;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Monitor: compare read data in the cycle the controller drives it.
    always @(negedge clk) begin
        if (rdPend) begin
            if (expQ.size() == 0) begin
                chk("rd-unexpected", busData, 8'hxx);
            end else begin
                chk(nmQ.pop_front(), busData, expQ.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bif.BUS_ADDR = a; bif.BUS_WE = 1'b1; tbData = d; tbDrive = 1'b1;
        tick();
        bif.BUS_ADDR = 8'h00; bif.BUS_WE = 1'b0; tbDrive = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e, input string nm);
        bif.BUS_ADDR = a; bif.BUS_WE = 1'b0; rdReq = 1'b1;
        expQ.push_back(e); nmQ.push_back(nm);
        tick();
        rdReq = 1'b0; bif.BUS_ADDR = 8'h00;
        tick();
    endtask

    task automatic ackInt();
        bif.INT_ACK = 1'b1;
        tick();
        bif.INT_ACK = 1'b0;
    endtask

    task automatic waitRaise(input string nm);
        int n;
        n = 0;
        while (!bif.INT_RAISE && n < 10) begin
            tick();
            n++;
        end
        chk(nm, {7'd0, bif.INT_RAISE}, 8'd1);
    endtask

    initial begin
        bif.BUS_ADDR = 8'h00; bif.BUS_WE = 1'b0; bif.SRC_RAISE = 8'h00; bif.INT_ACK = 1'b0;
        expVec[0] = 8'h83; expVec[1] = 8'h81; expVec[2] = 8'h83; expVec[3] = 8'h81;
        expVec[4] = 8'h83; expVec[5] = 8'h81; expVec[6] = 8'h81;
        repeat (3) tick();
        rstN = 1'b1;
        tick();

        // Reset state
        chk("rst-int", {7'd0, bif.INT_RAISE}, 8'd0);
        chk("rst-srcack", bif.SRC_ACK, 8'h00);
        rd(8'hD0, 8'h00, "rst-pending");
        rd(8'hD1, 8'h00, "rst-mask");
        rd(8'hD2, 8'h00, "rst-vector");
        rd(8'hD3, 8'h00, "rst-ctrl");
        rd(8'hCF, 8'hFF, "hiz-below");
        rd(8'hD4, 8'hFF, "hiz-above");

        // Fixed priority, two sources captured together
        wr(8'hD1, 8'h05);
        wr(8'hD3, 8'h01);
        bif.SRC_RAISE = 8'h05;
        tick();
        chk("fp-srcack", bif.SRC_ACK, 8'h05);
        bif.SRC_RAISE = 8'h00;
        tick();
        chk("fp-srcack-1cyc", bif.SRC_ACK, 8'h00);
        chk("fp-raise", {7'd0, bif.INT_RAISE}, 8'd1);
        ackInt();
        chk("fp-hold-low", {7'd0, bif.INT_RAISE}, 8'd0);
        tick();
        chk("fp-idle-low", {7'd0, bif.INT_RAISE}, 8'd0);
        rd(8'hD0, 8'h04, "fp-pending1");
        chk("fp-reraise", {7'd0, bif.INT_RAISE}, 8'd1);
        rd(8'hD2, 8'h80, "fp-vector1");
        ackInt();
        rd(8'hD2, 8'h82, "fp-vector2");
        rd(8'hD0, 8'h00, "fp-pending2");

        // Round-robin with sources 1 and 3 held; last serviced is 2 here
        wr(8'hD3, 8'h03);
        wr(8'hD1, 8'hFF);
        bif.SRC_RAISE = 8'h0A;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) wr(8'hD3, 8'h01);
            waitRaise("rr-raise");
            ackInt();
            rd(8'hD2, expVec[i], "rr-vector");
        end
        bif.SRC_RAISE = 8'h00;
        waitRaise("drain-raise1");
        ackInt();
        waitRaise("drain-raise2");
        ackInt();
        rd(8'hD0, 8'h00, "drain-pending");
        rd(8'hD2, 8'h83, "drain-vector");

        // Committed source survives masking and W1C
        wr(8'hD1, 8'h10);
        bif.SRC_RAISE = 8'h10;
        tick();
        chk("cm-srcack", bif.SRC_ACK, 8'h10);
        bif.SRC_RAISE = 8'h00;
        waitRaise("cm-raise");
        wr(8'hD1, 8'h00);
        wr(8'hD0, 8'h10);
        chk("cm-stay1", {7'd0, bif.INT_RAISE}, 8'd1);
        tick();
        chk("cm-stay2", {7'd0, bif.INT_RAISE}, 8'd1);
        ackInt();
        chk("cm-ack-low", {7'd0, bif.INT_RAISE}, 8'd0);
        rd(8'hD2, 8'h84, "cm-vector");
        rd(8'hD0, 8'h00, "cm-pending");

        // Capture beats W1C of the same bit; stray ack in IDLE ignored
        bif.SRC_RAISE = 8'h40;
        wr(8'hD0, 8'h40);
        chk("sim-srcack", bif.SRC_ACK, 8'h40);
        bif.SRC_RAISE = 8'h00;
        rd(8'hD0, 8'h40, "sim-pending");
        ackInt();
        chk("idle-ack-int", {7'd0, bif.INT_RAISE}, 8'd0);
        rd(8'hD2, 8'h84, "idle-ack-vector");
        rd(8'hD0, 8'h40, "idle-ack-pending");

        // MASK written in the same cycle IDLE evaluates: old mask applies
        wr(8'hD1, 8'h40);
        chk("oldmask-low", {7'd0, bif.INT_RAISE}, 8'd0);
        tick();
        chk("newmask-raise", {7'd0, bif.INT_RAISE}, 8'd1);

        // Reset while RAISED with a simultaneous ack
        rstN = 1'b0; bif.INT_ACK = 1'b1;
        tick();
        rstN = 1'b1; bif.INT_ACK = 1'b0;
        chk("mrst-int", {7'd0, bif.INT_RAISE}, 8'd0);
        rd(8'hD0, 8'h00, "mrst-pending");
        rd(8'hD1, 8'h00, "mrst-mask");
        rd(8'hD2, 8'h00, "mrst-vector");
        rd(8'hD3, 8'h00, "mrst-ctrl");
        chk("mrst-still-low", {7'd0, bif.INT_RAISE}, 8'd0);

        repeat (3) tick();
        chk("rd-queue-drained", 8'(expQ.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bus_irq_ctrl.md
Name: bus_irq_ctrl

Overview:
Parametrised interrupt controller on the shared 8-bit processor bus. It concentrates up to 8 peripheral interrupt sources onto one processor interrupt line, adding per-source pending/mask registers, fixed or round-robin priority, and a readable vector. It sits between the peripherals' raise/ack pairs and one of the processor's BUS_INTERRUPTS_RAISE/ACK lines, replacing direct point-to-point wiring.

Parameters:
BASE_ADDR, 8'hD0, first of 4 consecutive bus register addresses (BASE..BASE+3).
N_SRC, 8, number of interrupt sources (legal range 1..8).
MASK_RESET, 8'h00, reset value of MASK; bits at or above N_SRC are ignored.

Ports:
CLK  in  1  system clock; all state changes on the rising edge.
RESET  in  1  synchronous, active-low reset; state resets on a rising CLK edge when RESET=0.
BUS_ADDR  in  8  processor bus address.
BUS_DATA  inout  8  processor bus data; driven only during register reads, otherwise high-Z.
BUS_WE  in  1  bus write enable.
SRC_RAISE  in  N_SRC  per-source request; the peripheral holds it high until it sees SRC_ACK.
SRC_ACK  out  N_SRC  one-cycle pulse per source when its request is latched into PENDING.
INT_RAISE  out  1  interrupt to the processor.
INT_ACK  in  1  processor acknowledge, one-cycle pulse.

Behaviour:
- Reset values: PENDING=0, MASK=MASK_RESET, CTRL=0, VECTOR=0, last_serviced=N_SRC-1, FSM=IDLE, INT_RAISE=0, SRC_ACK=0, BUS_DATA high-Z.
- Capture: when SRC_RAISE[i]=1 and PENDING[i]=0, set PENDING[i] and pulse SRC_ACK[i] for exactly 1 cycle on the next cycle. A request held through the ACK cycle does not re-set the bit. Any number of sources may be captured in the same cycle.
- Registers:
  - BASE+0 PENDING: read returns the pending bits; a write clears each bit written as 1 (W1C).
  - BASE+1 MASK: read/write; 1 = source enabled.
  - BASE+2 VECTOR: read-only; bit7 = valid, bits[2:0] = index of the last acknowledged source, bits[6:3] = 0.
  - BASE+3 CTRL: bit0 = global enable (GEN), bit1 = round-robin mode (RR); bits[7:2] read back as 0.
- Writes take effect at the edge where BUS_WE=1 and the address matches.
- Reads: if BUS_ADDR is in range and BUS_WE=0, the register value is registered and BUS_DATA is driven the following cycle (1-cycle latency). BUS_DATA is high-Z otherwise.
- Unused source bits (index >= N_SRC) read as 0 and ignore writes.
- Eligible set: E = PENDING & MASK, gated by GEN.
- Selection:
  - RR=0: lowest index in E.
  - RR=1: first set bit of E searching from (last_serviced+1) mod N_SRC upward, wrapping.
- FSM:
  - IDLE: if E is non-zero, latch sel into cur and go to RAISED. INT_RAISE is registered and asserts on entry to RAISED.
  - RAISED: INT_RAISE=1. cur is committed: masking, W1C of that bit, or clearing GEN does not withdraw it. On INT_ACK: clear PENDING[cur], VECTOR<={1,0000,cur}, last_serviced<=cur, go to HOLD.
  - HOLD: INT_RAISE=0 for 1 cycle, then IDLE. This guarantees a low gap between back-to-back interrupts.
  - INT_ACK in IDLE or HOLD is ignored.
- Simultaneous events:
  - Capture set and W1C of the same bit in one cycle: set wins.
  - INT_ACK clear and capture of the same bit: capture wins (bit stays pending).
  - Bus write to MASK in the same cycle IDLE evaluates E: the old MASK is used.
- Reset mid-operation (any state) returns everything to the reset values at the next edge. An INT_ACK in that cycle is discarded.

Test Plan:
- Reset, then read BASE+0..3 with MASK_RESET=0 -> reads 00,00,00,00; INT_RAISE=0; BUS_DATA high-Z when the address is out of range.
- MASK=0x05, CTRL=0x01, pulse SRC_RAISE[2] and SRC_RAISE[0] in the same cycle -> SRC_ACK[0] and SRC_ACK[2] pulse 1 cycle; INT_RAISE rises. After INT_ACK: VECTOR=0x80, PENDING=0x04, INT_RAISE low for 1 cycle, then re-raises; after the second ACK: VECTOR=0x82, PENDING=0x00.
- RR=1 (CTRL=0x03), MASK=0xFF, hold sources 1 and 3 continuously re-raising -> vectors alternate 0x81, 0x83, 0x81, ...; with RR=0 -> always 0x81.
- In RAISED with cur=4, write MASK=0x00 and W1C PENDING=0x10 -> INT_RAISE stays 1 until INT_ACK; VECTOR=0x84.
- Same-cycle W1C of bit 6 and SRC_RAISE[6] capture -> PENDING[6]=1 afterwards; INT_ACK pulse while IDLE -> no state change.
- Assert RESET=0 for one cycle while RAISED -> INT_RAISE=0 and all registers at reset values on the next cycle; the next read of PENDING returns 0x00.
